// File: rtl/min_pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : min_pipe_pkg
//  Purpose  : Shared defaults, entry layout and stage-occupancy states for
//             the minimum-search pipeline register.
//  Contents : MIN_NUM_DEF / MIN_IDX_W_DEF / MIN_VAL_W_DEF   default geometry
//             min_entry_t                                   {trigger, idx, val}
//             min_state_t                                   EMPTY / ONE / FULL
//             min_entry_width()                             flat entry width
//  Revision : 1.0  initial release
// ============================================================================
package min_pipe_pkg;

  localparam int MIN_NUM_DEF   = 4;
  localparam int MIN_IDX_W_DEF = 16;
  localparam int MIN_VAL_W_DEF = 14;

  // Entry layout at default geometry; the flat vectors used in the RTL keep
  // the same field order (trigger in the MSB, values in the LSBs).
  typedef struct packed {
    logic                                 trigger;
    logic [MIN_NUM_DEF*MIN_IDX_W_DEF-1:0] idx;
    logic [MIN_NUM_DEF*MIN_VAL_W_DEF-1:0] val;
  } min_entry_t;

  // Occupancy of the stage: nothing, main register only, main + skid.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } min_state_t;

  function automatic int min_entry_width(input int num, input int idx_w, input int val_w);
    return 1 + num*idx_w + num*val_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/min_pipe_reg_entry.sv
`default_nettype none
// ============================================================================
//  Module   : min_entry_reg
//  Purpose  : Load-enabled register holding one flattened pipeline entry.
//             Clears to zero on reset; otherwise changes only when loaded.
//  Ports    : clk     clock
//             rst     synchronous active-high reset
//             i_load  capture i_d this cycle
//             i_d     entry to capture   [W-1:0]
//             o_q     held entry         [W-1:0]
//  Revision : 1.0  initial release
// ============================================================================
module min_entry_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/min_pipe_reg.sv
`default_nettype none
// ============================================================================
//  Module   : min_pipe_reg
//  Purpose  : Valid/ready pipeline register carrying a boss-trigger flag and
//             NUM_MIN index/value candidate pairs between MIN stages.
//             Holds data under backpressure, supports synchronous flush.
//  Build    : MIN_PIPE_SKID_EN defined   -> 2-entry skid, registered in_ready
//             MIN_PIPE_SKID_EN undefined -> single stage, combinational ready
//  Ports    : clk, rst (sync, active-high), flush
//             in_valid / in_ready / in_trigger / in_idx / in_val   upstream
//             out_valid / out_ready / out_trigger / out_idx / out_val downstream
//             pair k occupies [k*IDX_W +: IDX_W] and [k*VAL_W +: VAL_W]
//  Revision : 1.0  initial release
// ============================================================================
module min_pipe_reg
  import min_pipe_pkg::*;
#(
  parameter int NUM_MIN = MIN_NUM_DEF,
  parameter int IDX_W   = MIN_IDX_W_DEF,
  parameter int VAL_W   = MIN_VAL_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_trigger,
  input  logic [NUM_MIN*IDX_W-1:0] in_idx,
  input  logic [NUM_MIN*VAL_W-1:0] in_val,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_trigger,
  output logic [NUM_MIN*IDX_W-1:0] out_idx,
  output logic [NUM_MIN*VAL_W-1:0] out_val
);

  localparam int ENT_W = min_entry_width(NUM_MIN, IDX_W, VAL_W);

  logic [ENT_W-1:0] w_in_ent;
  logic [ENT_W-1:0] w_main_d;
  logic [ENT_W-1:0] w_main_q;
  logic             w_main_ld;
  logic             w_acc;
  logic             w_out;

  assign w_in_ent = {in_trigger, in_idx, in_val};

  // Flush suppresses the accept even when in_ready is high.
  assign w_acc = in_valid && in_ready && !flush;
  assign w_out = out_valid && out_ready;

  min_entry_reg #(.W(ENT_W)) u_main (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_main_ld),
    .i_d    (w_main_d),
    .o_q    (w_main_q)
  );

`ifdef MIN_PIPE_SKID_EN
  min_state_t       r_state;
  logic [ENT_W-1:0] w_skid_q;
  logic             w_skid_ld;

  min_entry_reg #(.W(ENT_W)) u_skid (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_skid_ld),
    .i_d    (w_in_ent),
    .o_q    (w_skid_q)
  );

  // Ready depends only on the state register (and reset), never on out_ready.
  assign in_ready  = !rst && (r_state != FULL);
  assign out_valid = (r_state != EMPTY);

  always_comb begin
    w_main_ld = 1'b0;
    w_skid_ld = 1'b0;
    w_main_d  = w_in_ent;
    if (!flush) begin
      case (r_state)
        EMPTY: w_main_ld = w_acc;
        ONE: begin
          // Stalled accept spills into the skid; otherwise main reloads.
          w_skid_ld = w_acc && !w_out;
          w_main_ld = w_acc && w_out;
        end
        FULL: begin
          w_main_ld = w_out;
          w_main_d  = w_skid_q;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= EMPTY;
    end else if (flush) begin
      r_state <= EMPTY;
    end else begin
      case (r_state)
        EMPTY:   if (w_acc) r_state <= ONE;
        ONE: begin
          if (w_acc && !w_out)      r_state <= FULL;
          else if (!w_acc && w_out) r_state <= EMPTY;
        end
        FULL:    if (w_out) r_state <= ONE;
        default: r_state <= EMPTY;
      endcase
    end
  end
`else
  logic r_valid;

  assign in_ready  = !rst && (!r_valid || out_ready);
  assign out_valid = r_valid;

  always_comb begin
    w_main_d  = w_in_ent;
    w_main_ld = w_acc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_acc) begin
      r_valid <= 1'b1;
    end else if (w_out) begin
      r_valid <= 1'b0;
    end
  end
`endif

  assign out_trigger = w_main_q[ENT_W-1];
  assign out_idx     = w_main_q[ENT_W-2 -: NUM_MIN*IDX_W];
  assign out_val     = w_main_q[NUM_MIN*VAL_W-1:0];

endmodule
`default_nettype wire

// File: tb/tb_min_pipe_reg.sv
`default_nettype none
// ============================================================================
//  Module   : tb_min_pipe_reg
//  Purpose  : Directed self-checking bench for min_pipe_reg (default geometry
//             plus an 8x10/12 instance). Skid-specific expectations are
//             selected with MIN_PIPE_SKID_EN.
//  Revision : 1.0  initial release
// ============================================================================
module tb_min_pipe_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid, in_ready, in_trigger;
  logic [63:0] in_idx;
  logic [55:0] in_val;
  logic        out_valid, out_ready, out_trigger;
  logic [63:0] out_idx;
  logic [55:0] out_val;

  logic        p_in_valid, p_in_ready, p_in_trigger;
  logic [79:0] p_in_idx;
  logic [95:0] p_in_val;
  logic        p_out_valid, p_out_ready, p_out_trigger;
  logic [79:0] p_out_idx;
  logic [95:0] p_out_val;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  min_pipe_reg u_dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_trigger(in_trigger),
    .in_idx(in_idx), .in_val(in_val),
    .out_valid(out_valid), .out_ready(out_ready), .out_trigger(out_trigger),
    .out_idx(out_idx), .out_val(out_val)
  );

  min_pipe_reg #(.NUM_MIN(8), .IDX_W(10), .VAL_W(12)) u_p (
    .clk(clk), .rst(rst), .flush(1'b0),
    .in_valid(p_in_valid), .in_ready(p_in_ready), .in_trigger(p_in_trigger),
    .in_idx(p_in_idx), .in_val(p_in_val),
    .out_valid(p_out_valid), .out_ready(p_out_ready), .out_trigger(p_out_trigger),
    .out_idx(p_out_idx), .out_val(p_out_val)
  );

  typedef struct packed {
    logic        t;
    logic [63:0] i;
    logic [55:0] v;
  } ent_t;

  ent_t q[$];
  ent_t e;

  // Values sampled just before each active edge.
  logic        s_in, s_out, s_rdy, s_trig, s_fl;
  logic [63:0] s_idx;
  logic [55:0] s_val;
  ent_t        s_in_ent;
  int          n_in, n_out, trig_in, trig_out;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: sample handshakes, step the edge, update the reference queue.
  task automatic tick();
    #1;
    s_rdy    = in_ready;
    s_fl     = flush;
    s_in     = in_valid && in_ready && !flush && !rst;
    s_out    = out_valid && out_ready && !rst;
    s_trig   = out_trigger;
    s_idx    = out_idx;
    s_val    = out_val;
    s_in_ent = '{t: in_trigger, i: in_idx, v: in_val};
    @(posedge clk);
    #1;
    if (s_fl) begin
      q.delete();
    end else begin
      if (s_out) begin
        n_out++;
        if (s_trig) trig_out++;
        if (q.size() == 0) begin
          chk("sb_pop_empty", 1, 0);
        end else begin
          e = q.pop_front();
          chk("sb_trig", s_trig, e.t);
          chk("sb_idx", s_idx, e.i);
          chk("sb_val", s_val, e.v);
        end
      end
      if (s_in) begin
        n_in++;
        if (s_in_ent.t) trig_in++;
        q.push_back(s_in_ent);
      end
    end
  endtask

  task automatic clr_counts();
    n_in = 0; n_out = 0; trig_in = 0; trig_out = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    logic [63:0] stall_idx;
    logic [79:0] p_exp_idx;
    logic [95:0] p_exp_val;

    clr_counts();
    rst = 1'b1; flush = 1'b0;
    in_valid = 1'b1; in_trigger = 1'b1; in_idx = 64'hFFFF; in_val = 56'h3FFF;
    out_ready = 1'b1;
    p_in_valid = 1'b0; p_in_trigger = 1'b0; p_in_idx = '0; p_in_val = '0;
    p_out_ready = 1'b1;

    // Reset held 3 cycles with an entry offered.
    repeat (3) begin
      @(posedge clk); #1;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_trigger", out_trigger, 0);
      chk("rst_out_idx", out_idx, 0);
      chk("rst_out_val", out_val, 0);
    end
    rst = 1'b0; in_valid = 1'b0;
    #1;
    chk("ready_after_rst", in_ready, 1);

    // Single pass.
    in_valid = 1'b1; in_trigger = 1'b1; in_idx = 64'h5; in_val = 56'h123;
    tick();
    chk("single_valid", out_valid, 1);
    chk("single_trig", out_trigger, 1);
    chk("single_idx", out_idx, 64'h5);
    chk("single_val", out_val, 56'h123);
    in_valid = 1'b0;
    tick();
    chk("single_drain", out_valid, 0);

    // Stream of 8 with out_ready high: 8 accepts in 8 cycles, 8 outputs in 9.
    clr_counts();
    n = 0;
    for (int c = 0; c < 8; c++) begin
      in_valid = 1'b1; in_trigger = n[0]; in_idx = 64'(n); in_val = 56'(256 + n);
      tick();
      if (s_in) n++;
    end
    chk("stream_accepts", n_in, 8);
    in_valid = 1'b0;
    tick();
    chk("stream_outs", n_out, 8);

    // Backpressure: out_ready low for cycles 4..7 of a 12-entry stream.
    clr_counts();
    n = 0;
    stall_idx = '0;
    for (int c = 0; c < 20; c++) begin
      out_ready  = !(c >= 4 && c < 8);
      in_valid   = (n < 12);
      in_trigger = n[1] ^ n[0];
      in_idx     = 64'(n);
      in_val     = 56'(512 + n);
      tick();
      if (s_in) n++;
      if (c >= 4 && c < 8) begin
        chk("bp_stall_valid", s_idx == 64'd3 ? 1'b1 : 1'b0, 1);
        chk("bp_stall_idx", s_idx, 64'd3);
      end
`ifdef MIN_PIPE_SKID_EN
      if (c == 4) chk("bp_skid_ready_c4", s_rdy, 1);
      if (c == 5) chk("bp_skid_ready_c5", s_rdy, 0);
      if (c == 7) chk("bp_skid_held", n_in - n_out, 2);
`else
      if (c == 4) chk("bp_ready_c4", s_rdy, 0);
      if (c == 7) chk("bp_held", n_in - n_out, 1);
`endif
    end
    chk("bp_count_in", n_in, 12);
    chk("bp_count_out", n_out, 12);
    chk("bp_trig_count", trig_out, trig_in);
    chk("bp_queue_empty", q.size(), 0);

    // Flush while holding entries, with a new entry offered.
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1; in_trigger = 1'b1; in_idx = 64'(32 + c); in_val = 56'(c);
      tick();
    end
`ifdef MIN_PIPE_SKID_EN
    chk("flush_pre_full", in_ready, 0);
`endif
    chk("flush_pre_valid", out_valid, 1);
    flush = 1'b1; in_valid = 1'b1; in_idx = 64'hBAD; in_trigger = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    chk("flush_out_valid", out_valid, 0);
    chk("flush_in_ready", in_ready, 1);
    repeat (3) begin
      tick();
      chk("flush_no_ghost", out_valid, 0);
    end
    in_valid = 1'b1; in_trigger = 1'b0; in_idx = 64'h42; in_val = 56'h7;
    tick();
    in_valid = 1'b0;
    chk("flush_recover_idx", out_idx, 64'h42);
    tick();

    // Wider geometry instance: pair k carries idx=k, val=0xF00+k.
    for (int k = 0; k < 8; k++) begin
      p_in_idx[k*10 +: 10] = 10'(k);
      p_in_val[k*12 +: 12] = 12'(12'hF00 + k);
    end
    p_exp_idx = p_in_idx;
    p_exp_val = p_in_val;
    p_in_valid = 1'b1; p_in_trigger = 1'b1;
    tick();
    p_in_valid = 1'b0;
    chk("p_valid", p_out_valid, 1);
    chk("p_trig", p_out_trigger, 1);
    for (int k = 0; k < 8; k++) begin
      chk("p_idx_slice", p_out_idx[k*10 +: 10], 10'(k));
      chk("p_val_slice", p_out_val[k*12 +: 12], 12'(12'hF00 + k));
    end
    chk("p_idx_whole", p_out_idx, p_exp_idx);
    chk("p_val_whole", p_out_val, p_exp_val);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
